// File: rtl/debug_master_wb_pkg.sv
// Shared types for the debug Wishbone initiator.
// FSM state encoding and response status codes.
package debug_master_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_BUSERR  = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT = 2'b10;

endpackage

// File: rtl/debug_master_wb.sv
// Debug command to Wishbone B4 pipelined single-beat initiator.
// Ports: cmd_* request in, rsp_* response out, wb_* bus master side.
module debug_master_wb
  import debug_master_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADR_W = 32,
  parameter int DAT_W = 32,
  localparam int SEL_W = DAT_W / 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [ADR_W-1:0] cmd_adr,
  input  logic [DAT_W-1:0] cmd_dat,
  input  logic [SEL_W-1:0] cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DAT_W-1:0] rsp_dat,
  output logic [1:0]       rsp_status,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [ADR_W-1:0] wb_adr_o,
  output logic [DAT_W-1:0] wb_dat_o,
  output logic [SEL_W-1:0] wb_sel_o,
  input  logic             wb_stall_i,
  input  logic             wb_ack_i,
  input  logic [DAT_W-1:0] wb_dat_i,
  input  logic             wb_err_i
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ?
    $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [31:0] TO =
    32'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_e           state_q;
  logic             rdy_q;
  logic             cyc_q;
  logic             stb_q;
  logic             we_q;
  logic [ADR_W-1:0] adr_q;
  logic [DAT_W-1:0] dat_q;
  logic [SEL_W-1:0] sel_q;
  logic             rv_q;
  logic [DAT_W-1:0] rdat_q;
  logic [1:0]       rst_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [31:0]      cnt_ext;
  logic             expire;

  assign cnt_d   = (cnt_q == CNT_MAX) ?
                   cnt_q : cnt_q + 1'b1;
  assign cnt_ext = 32'(cnt_q);
  // Expires on the edge where the
  // counter would reach the limit.
  assign expire  = (TO != 32'd0) &&
                   (cnt_ext + 32'd1 >= TO);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rv_q    <= 1'b0;
      rdat_q  <= '0;
      rst_q   <= RSP_OK;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid && rdy_q) begin
            we_q    <= cmd_we;
            adr_q   <= cmd_adr;
            dat_q   <= cmd_dat;
            sel_q   <= cmd_sel;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            state_q <= ST_REQ;
          end else begin
            rdy_q   <= 1'b1;
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_d;
          // ack/err here are protocol
          // violations and are ignored.
          if (expire) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            rv_q    <= 1'b1;
            rdat_q  <= '0;
            rst_q   <= RSP_TIMEOUT;
            state_q <= ST_RESP;
          end else if (!wb_stall_i) begin
            stb_q   <= 1'b0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_d;
          if (wb_err_i) begin
            cyc_q   <= 1'b0;
            rv_q    <= 1'b1;
            rdat_q  <= '0;
            rst_q   <= RSP_BUSERR;
            state_q <= ST_RESP;
          end else if (wb_ack_i) begin
            cyc_q   <= 1'b0;
            rv_q    <= 1'b1;
            rdat_q  <= we_q ? '0 : wb_dat_i;
            rst_q   <= RSP_OK;
            state_q <= ST_RESP;
          end else if (expire) begin
            cyc_q   <= 1'b0;
            rv_q    <= 1'b1;
            rdat_q  <= '0;
            rst_q   <= RSP_TIMEOUT;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rv_q    <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready  = rdy_q;
  assign rsp_valid  = rv_q;
  assign rsp_dat    = rdat_q;
  assign rsp_status = rst_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = stb_q;
  assign wb_we_o    = we_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = sel_q;

endmodule

// File: doc/debug_master_wb.md
Name: debug_master_wb

Overview:
- Wishbone B4 pipelined initiator that turns single debug commands (address, data, write/read, byte select) into one classic single-beat bus transaction at a time.
- Sits between the host-side command source (UART command decoder) and the system bus.
- Drives memories and peripherals, including the simulation debug/console responder.
- Returns read data or an error/timeout status on a valid/ready response channel.

Parameters:
- TIMEOUT_CYCLES, 255: cycles allowed from first stb assertion to ack/err before the transaction is aborted; 0 disables the timeout.
- ADR_W, 32: address width.
- DAT_W, 32: data width; SEL_W = DAT_W/8.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_we  in  1  1=write, 0=read
- cmd_adr  in  ADR_W  byte address
- cmd_dat  in  DAT_W  write data
- cmd_sel  in  SEL_W  byte lanes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_dat  out  DAT_W  read data; 0 for writes and errors
- rsp_status  out  2  00=OK, 01=bus error, 10=timeout
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  ADR_W  address
- wb_dat_o  out  DAT_W  write data
- wb_sel_o  out  SEL_W  byte select
- wb_stall_i  in  1  responder stall
- wb_ack_i  in  1  acknowledge
- wb_dat_i  in  DAT_W  read data
- wb_err_i  in  1  responder error

Behaviour:
- Single clock domain. Every output is registered.
- Synchronous active-high reset puts the FSM in IDLE and drives:
  - cyc, stb, we, rsp_valid = 0
  - adr, dat_o, sel, rsp_dat, rsp_status = 0
  - cmd_ready = 0 during reset
  - timeout counter = 0
- Reset mid-transaction drops cyc and stb on the next edge. The pending command and any response are discarded.
- FSM states:
  - IDLE: cmd_ready = 1. On cmd_valid, latch we/adr/dat/sel onto the bus registers, set cyc = stb = 1, clear the counter, go to REQ.
  - REQ: stb held with all bus fields stable. When wb_stall_i = 0 at the clock edge the request is accepted: stb goes 0, cyc stays 1, go to WAIT. If stall persists, stay in REQ.
  - WAIT: cyc = 1, stb = 0.
    - wb_err_i: status 01, rsp_dat 0.
    - Otherwise wb_ack_i: status 00; rsp_dat = wb_dat_i for reads, 0 for writes.
    - Either way: cyc goes 0, rsp_valid goes 1, go to RESP.
  - RESP: rsp_valid held with data and status stable until rsp_ready. Then rsp_valid goes 0 and the FSM returns to IDLE. cmd_ready is 0 here (one outstanding command).
- cmd_ready is high only in IDLE, so back-to-back throughput is one command per transaction.
- Latency with a zero-stall responder that acks one cycle after stb:
  - cmd handshake at edge N
  - stb high in cycle N+1
  - ack sampled at N+2
  - rsp_valid high from N+3
- Timeout counter:
  - Increments every cycle in REQ or WAIT and saturates.
  - When it reaches TIMEOUT_CYCLES with no ack/err that cycle: cyc and stb go 0, status 10, rsp_dat 0, go to RESP.
  - Ack or err in the same cycle as expiry takes priority over the timeout.
- Simultaneous ack and err: err wins (status 01).
- ack/err asserted while in REQ is a responder protocol violation and is ignored. ack/err in IDLE or RESP is ignored.
- wb_dat_i is sampled only on an ack edge in WAIT for a read.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, REQ, WAIT, RESP)
  - status constants RSP_OK = 2'b00, RSP_BUSERR = 2'b01, RSP_TIMEOUT = 2'b10
- No sub-module. The FSM, bus registers and timeout counter fit in one module.

Test Plan:
- Write 0x0000_0001 to 0x1000_0000, sel 0xF, responder acks one cycle after stb -> we = 1, adr/dat stable while stb high, stb high exactly 1 cycle, rsp_valid at N+3 with status 00 and rsp_dat 0, debug responder prints "Success!".
- Read 0x0000_0040, responder returns 0xDEADBEEF with 3 stall cycles -> stb high 4 cycles with fields stable, rsp_dat 0xDEADBEEF, status 00.
- Read with wb_err_i and wb_ack_i asserted together in WAIT -> status 01, rsp_dat 0, cyc drops on the next edge.
- TIMEOUT_CYCLES = 8, responder never acks -> cyc falls and status 10 is reported exactly 8 cycles after stb first rose; a late ack afterwards is ignored.
- rsp_ready held low 5 cycles, cmd_valid held high -> rsp_valid and data stable for those 5 cycles, cmd_ready stays 0, next command accepted in the cycle after IDLE is re-entered.
- wb_rst_i asserted while in WAIT -> next edge cyc = stb = rsp_valid = 0, cmd_ready = 0; cmd_ready returns to 1 in the first cycle after reset deasserts.
